riscv_vpu_lane_engine: RTL and testbench

Multi-cycle vector execution engine for the VPU. It accepts one vector request over a valid/ready handshake, processes LANES elements per cycle across up to MAX_VLEN elements, and returns a full result vector or a scalar reduction. Compared with the single-shot VPU request/response types, it adds:
- parametrised lane count, data width and vector length;
- a per-element mask;
- a full-length-capable vl field;
- response backpressure.
It sits between the decode/issue stage and writeback.

---
 rtl/riscv_vpu_types_pkg.sv | 56 +++++
 rtl/riscv_vpu_lane_alu.sv | 41 ++++
 rtl/riscv_vpu_lane_engine.sv | 214 +++++++++++++++++++++
 tb/tb_riscv_vpu_lane_engine.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_vpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_vpu_types_pkg
// Description : Shared VPU types: opcode encoding, engine FSM states, opcode
//               classification and reduction identity helpers.
// Revision    : 1.0 - initial lane-engine release
// ============================================================================
package riscv_vpu_types_pkg;

  typedef enum logic [3:0] {
    VPU_ADD     = 4'd0,
    VPU_SUB     = 4'd1,
    VPU_MUL     = 4'd2,
    VPU_DIV     = 4'd3,
    VPU_LOAD    = 4'd4,
    VPU_STORE   = 4'd5,
    VPU_RSUM    = 4'd6,
    VPU_RMIN    = 4'd7,
    VPU_RMAX    = 4'd8,
    VPU_PERMUTE = 4'd9
  } vpu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } vpu_state_e;

  // Opcodes the lane engine can execute; everything else is answered with an error.
  function automatic logic is_supported_op(vpu_op_e op);
    case (op)
      VPU_ADD, VPU_SUB, VPU_MUL, VPU_RSUM, VPU_RMIN, VPU_RMAX: is_supported_op = 1'b1;
      default:                                                 is_supported_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_reduction_op(vpu_op_e op);
    case (op)
      VPU_RSUM, VPU_RMIN, VPU_RMAX: is_reduction_op = 1'b1;
      default:                      is_reduction_op = 1'b0;
    endcase
  endfunction

  // Reduction identity for a given element width, returned in the low 'width' bits.
  function automatic logic [63:0] red_identity(vpu_op_e op, int unsigned width);
    logic [63:0] msb;
    msb = 64'd1 << (width - 1);
    case (op)
      VPU_RMIN: red_identity = msb - 64'd1;   // signed maximum
      VPU_RMAX: red_identity = msb;           // signed minimum
      default:  red_identity = '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_vpu_lane_alu.sv
`default_nettype none
// ============================================================================
// Module      : riscv_vpu_lane_alu
// Description : One combinational vector lane. Produces the element-wise
//               result and the lane's reduction candidate (identity when
//               the element is inactive).
// Revision    : 1.0 - initial lane-engine release
// ============================================================================
module riscv_vpu_lane_alu
  import riscv_vpu_types_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  vpu_op_e               op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  active_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic [DATA_WIDTH-1:0] red_o
);

  logic [DATA_WIDTH-1:0] ident;

  assign ident = DATA_WIDTH'(red_identity(op_i, DATA_WIDTH));

  // Element result (zero when inactive) and reduction candidate
  always_comb begin
    res_o = '0;
    red_o = active_i ? a_i : ident;
    if (active_i) begin
      case (op_i)
        VPU_ADD: res_o = a_i + b_i;
        VPU_SUB: res_o = a_i - b_i;
        VPU_MUL: res_o = a_i * b_i;   // low half of the product
        default: res_o = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_vpu_lane_engine.sv
`default_nettype none
// ============================================================================
// Module      : riscv_vpu_lane_engine
// Description : Multi-cycle vector engine. Accepts one request, processes
//               LANES elements per beat and returns either the full result
//               vector or a scalar reduction in element 0.
// Revision    : 1.0 - initial lane-engine release
// ============================================================================
module riscv_vpu_lane_engine
  import riscv_vpu_types_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_VLEN   = 16,
  parameter int LANES      = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [3:0]                     req_opcode_i,
  input  logic [$clog2(MAX_VLEN):0]      req_vl_i,
  input  logic [MAX_VLEN-1:0]            req_mask_i,
  input  logic [MAX_VLEN*DATA_WIDTH-1:0] req_op1_i,
  input  logic [MAX_VLEN*DATA_WIDTH-1:0] req_op2_i,
  input  logic [4:0]                     req_rd_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [MAX_VLEN*DATA_WIDTH-1:0] rsp_result_o,
  output logic                           rsp_error_o,
  output logic [4:0]                     rsp_rd_o,
  output logic                           busy_o
);

  localparam int EW  = $clog2(MAX_VLEN);
  localparam int VLW = EW + 1;
  localparam int VW  = MAX_VLEN * DATA_WIDTH;

  vpu_state_e            state_q,  state_d;
  vpu_op_e               op_q,     op_d;
  logic [VLW-1:0]        vl_q,     vl_d;
  logic [MAX_VLEN-1:0]   mask_q,   mask_d;
  logic [VW-1:0]         op1_q,    op1_d;
  logic [VW-1:0]         op2_q,    op2_d;
  logic [VW-1:0]         result_q, result_d;
  logic [DATA_WIDTH-1:0] acc_q,    acc_d;
  logic [EW-1:0]         base_q,   base_d;
  logic [4:0]            rd_q,     rd_d;
  logic                  error_q,  error_d;
  logic                  skip_q,   skip_d;

  logic [EW-1:0]         lane_idx [LANES];
  logic                  lane_act [LANES];
  logic [DATA_WIDTH-1:0] lane_a   [LANES];
  logic [DATA_WIDTH-1:0] lane_b   [LANES];
  logic [DATA_WIDTH-1:0] lane_res [LANES];
  logic [DATA_WIDTH-1:0] lane_red [LANES];
  logic [DATA_WIDTH-1:0] tree_red;
  logic [DATA_WIDTH-1:0] beat_red;
  logic                  last_beat;
  vpu_op_e               req_op;
  logic [DATA_WIDTH-1:0] req_ident;
  logic                  req_err;

  function automatic logic [DATA_WIDTH-1:0] red_merge(vpu_op_e op,
                                                      logic [DATA_WIDTH-1:0] x,
                                                      logic [DATA_WIDTH-1:0] y);
    case (op)
      VPU_RMIN: red_merge = ($signed(x) < $signed(y)) ? x : y;
      VPU_RMAX: red_merge = ($signed(x) > $signed(y)) ? x : y;
      default:  red_merge = x + y;
    endcase
  endfunction

  assign req_op    = vpu_op_e'(req_opcode_i);
  assign req_ident = DATA_WIDTH'(red_identity(req_op, DATA_WIDTH));
  assign req_err   = !is_supported_op(req_op) || (req_vl_i > VLW'(MAX_VLEN));
  assign last_beat = ({1'b0, base_q} + VLW'(LANES)) >= vl_q;

  // Route the current beat's elements to the lanes and qualify them by vl and mask
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = base_q + EW'(l);
      lane_act[l] = ({1'b0, lane_idx[l]} < vl_q) && mask_q[lane_idx[l]];
      lane_a[l]   = op1_q[int'(lane_idx[l]) * DATA_WIDTH +: DATA_WIDTH];
      lane_b[l]   = op2_q[int'(lane_idx[l]) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    riscv_vpu_lane_alu #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
      .op_i     (op_q),
      .a_i      (lane_a[l]),
      .b_i      (lane_b[l]),
      .active_i (lane_act[l]),
      .res_o    (lane_res[l]),
      .red_o    (lane_red[l])
    );
  end

  // Fold lane candidates, then merge with the running accumulator
  always_comb begin
    tree_red = lane_red[0];
    for (int l = 1; l < LANES; l++) begin
      tree_red = red_merge(op_q, tree_red, lane_red[l]);
    end
    beat_red = red_merge(op_q, acc_q, tree_red);
  end

  // Next-state and datapath updates. Error and empty requests still spend one
  // cycle in EXEC so every response appears at least one edge after accept.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    vl_d     = vl_q;
    mask_d   = mask_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    acc_d    = acc_q;
    base_d   = base_q;
    rd_d     = rd_q;
    error_d  = error_q;
    skip_d   = skip_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d     = req_op;
          vl_d     = req_vl_i;
          mask_d   = req_mask_i;
          op1_d    = req_op1_i;
          op2_d    = req_op2_i;
          rd_d     = req_rd_i;
          base_d   = '0;
          result_d = '0;
          acc_d    = req_ident;
          error_d  = req_err;
          skip_d   = req_err || (req_vl_i == '0);
          if (!req_err && (req_vl_i == '0) && is_reduction_op(req_op)) begin
            result_d[DATA_WIDTH-1:0] = req_ident;
          end
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (skip_q) begin
          state_d = RESP;
        end else begin
          if (is_reduction_op(op_q)) begin
            acc_d = beat_red;
          end else begin
            for (int l = 0; l < LANES; l++) begin
              result_d[int'(lane_idx[l]) * DATA_WIDTH +: DATA_WIDTH] = lane_res[l];
            end
          end
          base_d = base_q + EW'(LANES);
          if (last_beat) begin
            state_d = RESP;
            if (is_reduction_op(op_q)) begin
              result_d[DATA_WIDTH-1:0] = beat_red;
            end
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= VPU_ADD;
      vl_q     <= '0;
      mask_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      acc_q    <= '0;
      base_q   <= '0;
      rd_q     <= '0;
      error_q  <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      vl_q     <= vl_d;
      mask_q   <= mask_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      rd_q     <= rd_d;
      error_q  <= error_d;
      skip_q   <= skip_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign rsp_valid_o  = (state_q == RESP);
  assign busy_o       = (state_q != IDLE);
  assign rsp_result_o = result_q;
  assign rsp_error_o  = error_q;
  assign rsp_rd_o     = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_vpu_lane_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_vpu_lane_engine
// Description : Scoreboard bench for the vector lane engine. A reference
//               model computes each expected response when the request is
//               driven; a monitor pops and compares on every handshake.
// Revision    : 1.0 - initial lane-engine release
// ============================================================================
module tb_riscv_vpu_lane_engine;

  localparam int DW = 32;
  localparam int NV = 16;
  localparam int NL = 4;
  localparam int VW = NV * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [3:0]    req_opcode_i = '0;
  logic [4:0]    req_vl_i = '0;
  logic [NV-1:0] req_mask_i = '0;
  logic [VW-1:0] req_op1_i = '0;
  logic [VW-1:0] req_op2_i = '0;
  logic [4:0]    req_rd_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [VW-1:0] rsp_result_o;
  logic          rsp_error_o;
  logic [4:0]    rsp_rd_o;
  logic          busy_o;

  typedef struct {
    logic [VW-1:0] res;
    logic          err;
    logic [4:0]    rd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  riscv_vpu_lane_engine #(.DATA_WIDTH(DW), .MAX_VLEN(NV), .LANES(NL)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_opcode_i (req_opcode_i),
    .req_vl_i     (req_vl_i),
    .req_mask_i   (req_mask_i),
    .req_op1_i    (req_op1_i),
    .req_op2_i    (req_op2_i),
    .req_rd_i     (req_rd_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_error_o  (rsp_error_o),
    .rsp_rd_o     (rsp_rd_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of one request
  function automatic exp_t model(input int op, input int vl, input logic [NV-1:0] mask,
                                 input logic [VW-1:0] a, input logic [VW-1:0] b,
                                 input logic [4:0] rd);
    exp_t e;
    logic signed [DW-1:0] acc;
    logic signed [DW-1:0] x;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    e.res = '0;
    e.err = 1'b0;
    e.rd  = rd;
    if (!(op inside {0, 1, 2, 6, 7, 8}) || vl > NV) begin
      e.err = 1'b1;
      return e;
    end
    if (op == 7)      acc = 32'h7FFFFFFF;
    else if (op == 8) acc = 32'h80000000;
    else              acc = '0;
    for (int i = 0; i < NV; i++) begin
      if (i < vl && mask[i]) begin
        ea = a[i*DW +: DW];
        eb = b[i*DW +: DW];
        x  = ea;
        case (op)
          0: e.res[i*DW +: DW] = ea + eb;
          1: e.res[i*DW +: DW] = ea - eb;
          2: e.res[i*DW +: DW] = ea * eb;
          6: acc = acc + x;
          7: if (x < acc) acc = x;
          8: if (x > acc) acc = x;
          default: ;
        endcase
      end
    end
    if (op >= 6) e.res[DW-1:0] = acc;
    return e;
  endfunction

  // Drive one request, push its expectation, check latency, hold backpressure, complete handshake
  task automatic send(input int op, input int vl, input logic [NV-1:0] mask,
                      input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [4:0] rd,
                      input int exp_lat, input int hold);
    int   w;
    int   lat;
    exp_t e;
    logic [4:0] vl5;
    logic [3:0] op4;
    e   = model(op, vl, mask, a, b, rd);
    vl5 = vl[4:0];
    op4 = op[3:0];
    @(negedge clk);
    w = 0;
    while (!req_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", VW'(req_ready_o), VW'(1));
    req_valid_i  = 1'b1;
    req_opcode_i = op4;
    req_vl_i     = vl5;
    req_mask_i   = mask;
    req_op1_i    = a;
    req_op2_i    = b;
    req_rd_i     = rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    check("accepted_busy", VW'(busy_o), VW'(1));
    lat = 0;
    while (!rsp_valid_o && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", VW'(lat), VW'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      check("bp_valid", VW'(rsp_valid_o), VW'(1));
      check("bp_result", rsp_result_o, e.res);
      check("bp_req_ready", VW'(req_ready_o), VW'(0));
      @(posedge clk);
      #1;
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    check("idle_after_hs", VW'(req_ready_o), VW'(1));
  endtask

  // Monitor: compare every completed response against the scoreboard head
  always @(negedge clk) begin
    if (!rst && rsp_valid_o && rsp_ready_i) begin
      exp_t e;
      check("sb_nonempty", VW'(sb.size()), VW'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rsp_result", rsp_result_o, e.res);
        check("rsp_error", VW'(rsp_error_o), VW'(e.err));
        check("rsp_rd", VW'(rsp_rd_o), VW'(e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [NV-1:0] m;
    int stale;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_req_ready", VW'(req_ready_o), VW'(1));
    check("reset_rsp_valid", VW'(rsp_valid_o), VW'(0));
    check("reset_busy", VW'(busy_o), VW'(0));
    check("reset_error", VW'(rsp_error_o), VW'(0));
    check("reset_result", rsp_result_o, VW'(0));
    check("reset_rd", VW'(rsp_rd_o), VW'(0));

    // ADD, vl=5: op1[i]=i, op2[i]=10
    for (int i = 0; i < NV; i++) begin
      a[i*DW +: DW] = DW'(i);
      b[i*DW +: DW] = DW'(10);
    end
    send(0, 5, 16'hFFFF, a, b, 5'd3, 2, 0);

    // REDUCE_MAX, vl=16, mask=0x00FF, op1[i]=i-8
    for (int i = 0; i < NV; i++) a[i*DW +: DW] = DW'(i - 8);
    send(8, 16, 16'h00FF, a, b, 5'd7, 4, 0);

    // REDUCE_MIN with no active elements -> identity
    send(7, 4, 16'h0000, a, b, 5'd9, 1, 0);

    // MUL truncation: 0x10000*0x10000 -> 0, plus a non-trivial second element
    a = '0;
    b = '0;
    a[0 +: DW]  = 32'h00010000;
    b[0 +: DW]  = 32'h00010000;
    a[DW +: DW] = 32'h00012345;
    b[DW +: DW] = 32'h00000007;
    send(2, 2, 16'hFFFF, a, b, 5'd11, 1, 0);

    // Unsupported opcode, illegal code, oversized vl
    send(3, 3, 16'hFFFF, a, b, 5'd12, 1, 0);
    send(12, 4, 16'hFFFF, a, b, 5'd13, 1, 0);
    send(0, 17, 16'hFFFF, a, b, 5'd14, 1, 0);

    // vl == 0 for element-wise and reduction
    send(0, 0, 16'hFFFF, a, b, 5'd15, 1, 0);
    send(8, 0, 16'hFFFF, a, b, 5'd16, 1, 0);

    // Backpressure: SUB with random data held 5 cycles, then an immediate RSUM
    for (int i = 0; i < NV; i++) begin
      a[i*DW +: DW] = $urandom;
      b[i*DW +: DW] = $urandom;
    end
    m = NV'($urandom);
    send(1, 16, m, a, b, 5'd21, 4, 5);
    m = NV'($urandom);
    send(6, 7, m, a, b, 5'd22, 2, 0);

    // Reset during beat 1 of a 4-beat reduction
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_opcode_i = 4'd6;
    req_vl_i     = 5'd16;
    req_mask_i   = 16'hFFFF;
    req_rd_i     = 5'd30;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    check("rst_test_busy", VW'(busy_o), VW'(1));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rsp_valid", VW'(rsp_valid_o), VW'(0));
    check("midrst_busy", VW'(busy_o), VW'(0));
    check("midrst_req_ready", VW'(req_ready_o), VW'(1));
    rst = 1'b0;
    stale = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (rsp_valid_o) stale++;
    end
    check("no_stale_rsp", VW'(stale), VW'(0));

    // Signed REDUCE_MIN over three beats after reset
    for (int i = 0; i < NV; i++) a[i*DW +: DW] = $urandom;
    m = NV'($urandom) | 16'h0100;
    send(7, 9, m, a, b, 5'd5, 3, 0);

    repeat (3) @(posedge clk);
    check("sb_drained", VW'(sb.size()), VW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
